gpio_port_ctrl: RTL

Parametrised memory-mapped GPIO controller on the CPU data bus, successor to the fixed 8-bit GPIO port. Provides per-pin direction control, a multi-stage input synchroniser, per-pin edge detection with sticky status, and a level interrupt to the CPU. Register writes are synchronous. Reads are combinational so a single-cycle CPU can use them in the same cycle.

---
 rtl/gpio_port_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/gpio_port_ctrl.sv
// Memory-mapped GPIO controller: direction, output and input registers, a configurable-depth
// input synchroniser, per-pin edge detection with sticky status, and a level interrupt.
module gpio_port_ctrl #(
  parameter int unsigned GPIO_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  input  logic                  Select,
  input  logic                  Write,
  input  logic [GPIO_WIDTH-1:0] GPIO_In,
  output logic [GPIO_WIDTH-1:0] GPIO_Out,
  output logic [GPIO_WIDTH-1:0] GPIO_OE,
  output logic                  IRQ
);

  localparam int unsigned W = GPIO_WIDTH;

  localparam logic [2:0] IDX_OUT      = 3'd0;
  localparam logic [2:0] IDX_IN       = 3'd1;
  localparam logic [2:0] IDX_DIR      = 3'd2;
  localparam logic [2:0] IDX_IRQ_EN   = 3'd3;
  localparam logic [2:0] IDX_EDGE_SEL = 3'd4;
  localparam logic [2:0] IDX_STATUS   = 3'd5;

  logic [W-1:0] out_q;
  logic [W-1:0] dir_q;
  logic [W-1:0] irq_en_q;
  logic [W-1:0] edge_sel_q;
  logic [W-1:0] status_q;
  logic [W-1:0] prev_q;
  logic         irq_q;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;

  logic         wr_en;
  logic [2:0]   idx;
  logic [W-1:0] wdata;
  logic [W-1:0] in_sync;
  logic [W-1:0] evt;
  logic [W-1:0] clr;
  logic [W-1:0] status_d;
  logic [W-1:0] irq_en_d;
  logic         irq_d;
  logic [W-1:0] rd_data;

  // Only Address[4:2] and DataIn[W-1:0] carry meaning; the rest is ignored.
  logic unused_bits;
  assign unused_bits = ^{Address[31:5], Address[1:0], DataIn};

  // Next-state for sticky status and interrupt; a new event beats a same-cycle clear.
  always_comb begin
    wr_en    = Select & Write;
    idx      = Address[4:2];
    wdata    = DataIn[W-1:0];
    in_sync  = sync_q[SYNC_STAGES-1];
    evt      = (edge_sel_q & in_sync & ~prev_q) | (~edge_sel_q & ~in_sync & prev_q);
    clr      = (wr_en && idx == IDX_STATUS) ? wdata : '0;
    status_d = (status_q & ~clr) | evt;
    irq_en_d = (wr_en && idx == IDX_IRQ_EN) ? wdata : irq_en_q;
    irq_d    = |(status_d & irq_en_d);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      status_q   <= '0;
      prev_q     <= '0;
      irq_q      <= 1'b0;
      sync_q     <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], GPIO_In};
      prev_q   <= in_sync;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      if (wr_en) begin
        case (idx)
          IDX_OUT:      out_q      <= wdata;
          IDX_DIR:      dir_q      <= wdata;
          IDX_EDGE_SEL: edge_sel_q <= wdata;
          default:      ;
        endcase
      end
    end
  end

  // Combinational read path, zero outside a selected read.
  always_comb begin
    rd_data = '0;
    if (Select && !Write) begin
      case (idx)
        IDX_OUT:      rd_data = out_q;
        IDX_IN:       rd_data = in_sync;
        IDX_DIR:      rd_data = dir_q;
        IDX_IRQ_EN:   rd_data = irq_en_q;
        IDX_EDGE_SEL: rd_data = edge_sel_q;
        IDX_STATUS:   rd_data = status_q;
        default:      rd_data = '0;
      endcase
    end
    DataOut = 32'(rd_data);
  end

  assign GPIO_Out = out_q;
  assign GPIO_OE  = dir_q;
  assign IRQ      = irq_q;

endmodule
